muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 3: RUN-state cycles for MUL/MULH/MULHSU/MULHU (E_md_op_i[2]=0); legal range 1..63.
REQ-002 Parameter DIV_LAT, default 33: RUN-state cycles for DIV/DIVU/REM/REMU (E_md_op_i[2]=1); legal range 1..63.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 E_md_req_i  input  1  E stage holds a valid M-extension instruction.
REQ-006 E_md_op_i  input  3  funct3 of that instruction.
REQ-007 E_dstE_i  input  5  destination register of that instruction.
REQ-008 E_div_zero_i  input  1  divisor operand is zero.
REQ-009 flush_i  input  1  pipeline redirect; kills the E-stage instruction.
REQ-010 unit_start_o  output  1  one-cycle pulse; arithmetic unit loads its operands.
REQ-011 unit_op_o  output  3  latched op presented to the unit.
REQ-012 unit_step_o  output  1  unit advances one iteration.
REQ-013 md_stall_o  output  1  hazard request: stall PC/F/D/E and bubble M.
REQ-014 md_wb_valid_o  output  1  one-cycle pulse; result is valid for writeback.
REQ-015 md_dstE_o  output  5  latched destination register.
REQ-016 busy_o  output  1  FSM is not IDLE.

Function
REQ-017 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-018 In IDLE, if E_md_req_i=1 and flush_i=0, the block SHALL pulse unit_start_o and latch op/dstE into unit_op_o/md_dstE_o.
- Same cycle: load counter with LAT-1 (LAT is MUL_LAT or DIV_LAT per op[2]).
- Next state: RUN.
REQ-019 In RUN, the block SHALL assert unit_step_o every cycle.
- Counter nonzero: decrement it.
- Counter zero: go to DONE.
- RUN therefore lasts exactly LAT cycles.
REQ-020 In DONE, the block SHALL pulse md_wb_valid_o for one cycle and return to IDLE.
- DONE ignores E_md_req_i, so the held instruction is never restarted.
REQ-021 md_stall_o SHALL equal (IDLE & E_md_req_i & ~flush_i) | (RUN & ~flush_i), combinationally.
- Stall length: LAT+1 cycles.
- md_wb_valid_o is asserted LAT+1 cycles after the issue cycle.
REQ-022 If flush_i=1 in RUN, the block SHALL go to IDLE next cycle with no md_wb_valid_o pulse.
REQ-023 If flush_i=1 in DONE, the block SHALL still assert md_wb_valid_o, because the instruction has already left E.
REQ-024 Back-to-back requests: a new request seen in the IDLE cycle after DONE SHALL start with no gap cycle beyond that IDLE.
REQ-025 Counter width SHALL be 6 bits; no wrap-around; the counter holds at 0 outside RUN.
REQ-026 unit_step_o and unit_start_o SHALL never be asserted in the same cycle.

Reset
REQ-027 While rst=1, the block SHALL hold:
- state = IDLE, counter = 0;
- unit_op_o = 0, md_dstE_o = 0;
- unit_start_o, unit_step_o, md_wb_valid_o, busy_o all 0.
- md_stall_o follows REQ-021 for the IDLE state.
REQ-028 Reset asserted mid-RUN SHALL abort the operation immediately (asynchronously), with no writeback pulse after release.

Configuration
REQ-029 Macro MULDIV_EARLY_OUT_EN, when defined, SHALL load the counter with 0 when op[2]=1 and E_div_zero_i=1.
- Effect: RUN lasts 1 cycle, stall lasts 2 cycles.
REQ-030 Without MULDIV_EARLY_OUT_EN, divide-by-zero SHALL take the full DIV_LAT.

Verification
REQ-031 MUL: req=1, op=000, dst=5 at cycle 0 -> start pulse c0; step c1-c3; stall c0-c3; wb_valid c4 with md_dstE_o=5.
REQ-032 DIVU: op=101, divisor nonzero at c0 -> step c1-c33; stall c0-c33; wb_valid c34.
REQ-033 DIV, divisor zero -> wb_valid at c2 with MULDIV_EARLY_OUT_EN defined; at c34 without it.
REQ-034 Flush: flush_i=1 at c10 of a DIV -> stall 0 in c10; IDLE at c11; no wb_valid ever.
REQ-035 Back-to-back: MUL at c0, MUL at c5 -> wb_valid at c4 and c9; no start while in DONE.
REQ-036 Reset: rst pulse at c7 of a DIV -> busy_o=0 immediately; no wb_valid after release.

Source files
------------

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : IDLE/RUN/DONE sequencer for a multi-cycle M-extension unit;
//            raises the pipeline stall and issues the writeback pulse.
// Options  : MULDIV_EARLY_OUT_EN - divide-by-zero finishes after one RUN cycle
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E_md_req_i,
  input  logic [2:0] E_md_op_i,
  input  logic [4:0] E_dstE_i,
  input  logic       E_div_zero_i,
  input  logic       flush_i,
  output logic       unit_start_o,
  output logic [2:0] unit_op_o,
  output logic       unit_step_o,
  output logic       md_stall_o,
  output logic       md_wb_valid_o,
  output logic [4:0] md_dstE_o,
  output logic       busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] c_MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] c_DIV_LOAD = 6'(DIV_LAT - 1);

  logic [1:0] r_state;
  logic [5:0] r_cnt;
  logic [2:0] r_op;
  logic [4:0] r_dst;

  logic       w_issue;
  logic       w_early;
  logic [5:0] w_load;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = E_md_op_i[2] & E_div_zero_i;
`else
  logic w_unused;
  assign w_unused = E_div_zero_i;
  assign w_early  = 1'b0;
`endif

  assign w_issue = (r_state == S_IDLE) & E_md_req_i & ~flush_i;

  always_comb begin
    w_load = E_md_op_i[2] ? c_DIV_LOAD : c_MUL_LOAD;
    if (w_early) begin
      w_load = 6'd0;
    end
  end

  // Counter holds LAT-1 on entry so RUN lasts exactly LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_op    <= 3'd0;
      r_dst   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_op    <= E_md_op_i;
            r_dst   <= E_dstE_i;
            r_cnt   <= w_load;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush_i) begin
            r_cnt   <= 6'd0;
            r_state <= S_IDLE;
          end else if (r_cnt == 6'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= 6'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The stall in DONE is dropped so the finished instruction can leave E.
  assign md_stall_o    = w_issue | ((r_state == S_RUN) & ~flush_i);
  assign unit_start_o  = w_issue & ~rst;
  assign unit_step_o   = (r_state == S_RUN);
  assign md_wb_valid_o = (r_state == S_DONE);
  assign busy_o        = (r_state != S_IDLE);
  assign unit_op_o     = r_op;
  assign md_dstE_o     = r_dst;

endmodule
`default_nettype wire
